iomem_bus_ctrl: RTL and testbench

- Two-port bus controller that owns the chip-select / address-latch / strobe bus of the byte-wide I/O memory.
- Arbitrates between requester ports 0 and 1, then sequences each transaction through the memory's five-phase protocol.
- Drives and releases the shared bidirectional data bus, returns read data, and issues a completion pulse.
- Sits between the system-side masters and the memory; it is the only driver of the memory's control pins.

---
 rtl/iomem_bus_ctrl.sv | 143 ++++++++++++++
 tb/tb_iomem_bus_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/iomem_bus_ctrl.sv
// iomem_bus_ctrl: two-port arbiter and five-phase (IDLE/ADDR/CMD/DATA/RECOV) sequencer for the byte-wide I/O memory.
// Option macro IOMEM_ARB_RR_EN: round-robin tie-break; undefined gives fixed priority to port 0.
`default_nettype none

module iomem_bus_ctrl #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              REQ0,
  input  logic              REQ1,
  input  logic              WE0,
  input  logic              WE1,
  input  logic [ADDR_W-1:0] ADDR0,
  input  logic [ADDR_W-1:0] ADDR1,
  input  logic [DATA_W-1:0] WDATA0,
  input  logic [DATA_W-1:0] WDATA1,
  output logic              ACK0,
  output logic              ACK1,
  output logic [DATA_W-1:0] RDATA0,
  output logic [DATA_W-1:0] RDATA1,
  output logic              BUSY,
  output logic              CS,
  output logic              ALE,
  output logic              RD,
  output logic              WR,
  output logic [ADDR_W-1:0] Address,
  inout  wire  [DATA_W-1:0] Data
);

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_ADDR  = 5'b00010,
    S_CMD   = 5'b00100,
    S_DATA  = 5'b01000,
    S_RECOV = 5'b10000
  } state_t;

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic                owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                ack0_q, ack0_d, ack1_q, ack1_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                gnt_port;

`ifdef IOMEM_ARB_RR_EN
  logic                last_q, last_d;

  // On a tie the port not served last wins; a lone requester always wins.
  assign gnt_port = (REQ0 && REQ1) ? ~last_q : REQ1;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) last_q <= 1'b1;
    else          last_q <= last_d;
  end

  always_comb begin
    last_d = last_q;
    if (state_q == S_IDLE && (REQ0 || REQ1)) last_d = gnt_port;
  end
`else
  assign gnt_port = ~REQ0;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      owner_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      S_IDLE: begin
        if (REQ0 || REQ1) begin
          state_d = S_ADDR;
          owner_d = gnt_port;
          we_d    = gnt_port ? WE1    : WE0;
          addr_d  = gnt_port ? ADDR1  : ADDR0;
          wdata_d = gnt_port ? WDATA1 : WDATA0;
        end
      end
      S_ADDR: state_d = S_CMD;
      S_CMD:  state_d = S_DATA;
      S_DATA: begin
        // Read data is captured on the same edge that raises the owner's ACK.
        state_d = S_RECOV;
        ack0_d  = ~owner_q;
        ack1_d  = owner_q;
        if (!we_q) begin
          if (owner_q) rdata1_d = Data;
          else         rdata0_d = Data;
        end
      end
      S_RECOV: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign BUSY    = (state_q != S_IDLE);
  assign CS      = (state_q == S_ADDR) || (state_q == S_CMD) || (state_q == S_DATA);
  assign ALE     = (state_q == S_ADDR);
  assign RD      = ~((state_q == S_CMD) && !we_q);
  assign WR      = ~((state_q == S_CMD) && we_q);
  assign Address = addr_q;
  assign Data    = (((state_q == S_CMD) || (state_q == S_DATA)) && we_q) ? wdata_q : {DATA_W{1'bz}};
  assign ACK0    = ack0_q;
  assign ACK1    = ack1_q;
  assign RDATA0  = rdata0_q;
  assign RDATA1  = rdata1_q;

endmodule

`default_nettype wire

// File: tb/tb_iomem_bus_ctrl.sv
// Randomized bench for iomem_bus_ctrl with a pin-level memory model and a transaction-level reference.
`default_nettype none

module tb_iomem_bus_ctrl;
  localparam int AW = 20;
  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic          REQ0 = 1'b0, REQ1 = 1'b0, WE0 = 1'b0, WE1 = 1'b0;
  logic [AW-1:0] ADDR0 = '0, ADDR1 = '0;
  logic [DW-1:0] WDATA0 = '0, WDATA1 = '0;
  logic          ACK0, ACK1, BUSY, CS, ALE, RD, WR;
  logic [DW-1:0] RDATA0, RDATA1;
  logic [AW-1:0] Address;
  wire  [DW-1:0] Data;

  iomem_bus_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
    .ACK0(ACK0), .ACK1(ACK1), .RDATA0(RDATA0), .RDATA1(RDATA1),
    .BUSY(BUSY), .CS(CS), .ALE(ALE), .RD(RD), .WR(WR),
    .Address(Address), .Data(Data)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Memory device model: drives Data during a read, commits on the edge leaving DATA.
  // While CS is low the bench drives a probe value so a leaking controller driver shows up.
  logic [7:0] mem [256];
  bit         wrt [256];
  logic [7:0] probe_val = 8'h5A;
  logic       rd_seen = 1'b0, wr_seen = 1'b0;
  logic [7:0] mem_q;
  wire        mem_rd = CS && !ALE && (!RD || rd_seen);

  assign mem_q = wrt[Address[7:0]] ? mem[Address[7:0]] : (Address[7:0] ^ 8'h96);
  assign Data  = !CS ? probe_val : (mem_rd ? mem_q : 8'hzz);

  always @(posedge CLK) begin
    if (CS && !ALE && RD && WR && wr_seen) begin
      mem[Address[7:0]] <= Data;
      wrt[Address[7:0]] <= 1'b1;
    end
    rd_seen <= CS && (rd_seen || !RD);
    wr_seen <= CS && (wr_seen || !WR);
  end

  always @(negedge CLK) if (RESET_N) chk("rdwr_excl", {31'd0, (!RD && !WR)}, 32'd0);

  // Transaction-level reference state
  logic          pend [2];
  logic          pwe  [2];
  logic [AW-1:0] paddr[2];
  logic [DW-1:0] pwd  [2];
  logic [DW-1:0] exp_rd[2];
  logic [DW-1:0] ref_mem[256];
  logic          last_p;

  task automatic drive_reqs();
    REQ0 = pend[0]; WE0 = pwe[0]; ADDR0 = paddr[0]; WDATA0 = pwd[0];
    REQ1 = pend[1]; WE1 = pwe[1]; ADDR1 = paddr[1]; WDATA1 = pwd[1];
  endtask

  task automatic new_req(input int p);
    pend[p]  = 1'b1;
    pwe[p]   = 1'($urandom);
    paddr[p] = AW'($urandom);
    pwd[p]   = DW'($urandom);
  endtask

  // Called at a negedge while the controller is idle; mode 0 drops REQ at ACK,
  // 1 keeps REQ high with fresh fields, 2 picks one at random.
  task automatic run_one(input int mode);
    int w;
    logic [7:0] rv;
    logic [AW-1:0] a;
`ifdef IOMEM_ARB_RR_EN
    w = (pend[0] && pend[1]) ? int'(!last_p) : (pend[0] ? 0 : 1);
`else
    w = pend[0] ? 0 : 1;
`endif
    last_p = w[0];
    drive_reqs();
    probe_val = pwe[w] ? ~pwd[w] : 8'($urandom);
    a  = paddr[w];
    rv = ref_mem[a[7:0]];
    chk("idle_busy", {31'd0, BUSY}, 32'd0);
    @(negedge CLK);
    chk("c1_ctrl", {BUSY, CS, ALE, RD, WR}, 5'b11111);
    chk("c1_addr", Address, a);
    chk("c1_ack", {ACK1, ACK0}, 2'b00);
    @(negedge CLK);
    chk("c2_ctrl", {BUSY, CS, ALE, RD, WR}, {3'b110, pwe[w], !pwe[w]});
    chk("c2_data", Data, pwe[w] ? pwd[w] : rv);
    chk("c2_ack", {ACK1, ACK0}, 2'b00);
    @(negedge CLK);
    chk("c3_ctrl", {BUSY, CS, ALE, RD, WR}, 5'b11011);
    chk("c3_data", Data, pwe[w] ? pwd[w] : rv);
    chk("c3_addr", Address, a);
    @(negedge CLK);
    chk("c4_ctrl", {BUSY, CS, ALE, RD, WR}, 5'b10011);
    chk("c4_ack", {ACK1, ACK0}, (w == 1) ? 2'b10 : 2'b01);
    chk("c4_release", Data, probe_val);
    if (pwe[w]) ref_mem[a[7:0]] = pwd[w];
    else        exp_rd[w] = rv;
    chk("c4_rdata0", RDATA0, exp_rd[0]);
    chk("c4_rdata1", RDATA1, exp_rd[1]);
    if (mode == 1 || (mode == 2 && $urandom_range(1) == 1)) new_req(w);
    else pend[w] = 1'b0;
    drive_reqs();
    @(negedge CLK);
    chk("c5_ctrl", {BUSY, CS, ALE, RD, WR}, 5'b00011);
    chk("c5_ack", {ACK1, ACK0}, 2'b00);
    chk("c5_addr", Address, a);
    chk("c5_release", Data, probe_val);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h96;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; pwe[p] = 1'b0; paddr[p] = '0; pwd[p] = '0; exp_rd[p] = '0;
    end
    last_p = 1'b1;
    drive_reqs();
    repeat (2) @(negedge CLK);
    chk("rst_ctrl", {BUSY, CS, ALE, RD, WR}, 5'b00011);
    chk("rst_addr", Address, 20'd0);
    chk("rst_ack", {ACK1, ACK0}, 2'b00);
    chk("rst_rdata", {RDATA1, RDATA0}, 16'd0);
    chk("rst_data", Data, probe_val);
    RESET_N = 1'b1;
    @(negedge CLK);

    // Single write then read on port 0, then a port-1 read of word 0.
    pend[0] = 1'b1; pwe[0] = 1'b1; paddr[0] = 20'h00010; pwd[0] = 8'hA5;
    run_one(0);
    pend[0] = 1'b1; pwe[0] = 1'b0; paddr[0] = 20'h00010;
    run_one(0);
    chk("wr_rd_A5", RDATA0, 8'hA5);
    pend[1] = 1'b1; pwe[1] = 1'b0; paddr[1] = 20'h00000;
    run_one(0);

    // Both ports held high for three transactions, then port 0 drops.
    new_req(0); new_req(1);
    repeat (3) run_one(1);
    pend[0] = 1'b0;
    run_one(0);
    pend[0] = 1'b0; pend[1] = 1'b0;

    // Reset during DATA of a write to 0x20: nothing committed, no ACK.
    pend[0] = 1'b1; pwe[0] = 1'b1; paddr[0] = 20'h00020; pwd[0] = 8'hC3;
    drive_reqs();
    probe_val = 8'h3C;
    repeat (3) @(negedge CLK);
    chk("rt_in_data", {CS, ALE, RD, WR}, 4'b1011);
    RESET_N = 1'b0;
    #1;
    chk("rt_ctrl", {BUSY, CS, ALE, RD, WR}, 5'b00011);
    chk("rt_data", Data, 8'h3C);
    chk("rt_ack", {ACK1, ACK0}, 2'b00);
    chk("rt_addr", Address, 20'd0);
    pend[0] = 1'b0;
    drive_reqs();
    @(negedge CLK);
    chk("rt_noack", {ACK1, ACK0}, 2'b00);
    RESET_N = 1'b1;
    last_p = 1'b1;
    exp_rd[0] = '0; exp_rd[1] = '0;
    @(negedge CLK);
    chk("rt_busy", {31'd0, BUSY}, 32'd0);
    pend[0] = 1'b1; pwe[0] = 1'b0; paddr[0] = 20'h00020;
    run_one(0);

    // Random traffic with ties, held requests and back-to-back grants.
    repeat (200) begin
      for (int p = 0; p < 2; p++) if (!pend[p] && $urandom_range(1) == 1) new_req(p);
      if (!pend[0] && !pend[1]) new_req(int'($urandom_range(1)));
      run_one(2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
